// File: rtl/tile_block.sv
// Background tile renderer: maps a 640x480 scan position onto a centred 28x36 tile playfield.
// Four streaming register stages: VRAM address, tile ROM address, palette ROM address, RGB.
module tile_block #(
    parameter int          H_OFF         = 208,
    parameter int          V_OFF         = 96,
    parameter logic [15:0] TILE_RAM_BASE = 16'h4000,
    parameter logic [15:0] PAL_RAM_BASE  = 16'h4400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    output logic [15:0] tile_RAM_addr,
    input  logic [7:0]  tile_RAM_data,
    output logic [15:0] palette_RAM_addr,
    input  logic [7:0]  palette_RAM_data,
    output logic [11:0] tile_ROM_addr,
    input  logic [7:0]  tile_ROM_data,
    output logic [7:0]  palette_ROM_addr,
    input  logic [7:0]  palette_ROM_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    logic [15:0] tile_ram_addr_d, tile_ram_addr_q;
    logic [15:0] pal_ram_addr_d, pal_ram_addr_q;
    logic [2:0]  py1_d, py1_q;
    logic [2:0]  px1_d, px1_q;
    logic        act1_d, act1_q;

    logic [11:0] tile_rom_addr_d, tile_rom_addr_q;
    logic [5:0]  pal_code_d, pal_code_q;
    logic [1:0]  px2_d, px2_q;
    logic        act2_d, act2_q;

    logic [7:0]  pal_rom_addr_d, pal_rom_addr_q;
    logic        act3_d, act3_q;

    logic [3:0]  red_d, red_q;
    logic [3:0]  green_d, green_q;
    logic [3:0]  blue_d, blue_q;

    logic [8:0]  row_rel;
    logic [7:0]  col_rel;
    logic [5:0]  ty;
    logic [4:0]  tx;
    logic [4:0]  inv_tx;
    logic [9:0]  offset;
    logic [1:0]  pixel;
    logic        active;

    logic unused_pal_bits;
    assign unused_pal_bits = &{1'b0, palette_RAM_data[7:6]};

    always_comb begin
        row_rel = row - 9'(V_OFF);
        col_rel = 8'(col - 10'(H_OFF));
        active  = (row >= 9'(V_OFF)) && (row < 9'(V_OFF + 288)) &&
                  (col >= 10'(H_OFF)) && (col < 10'(H_OFF + 224));
        ty      = row_rel[8:3];
        tx      = col_rel[7:3];
        inv_tx  = 5'd27 - tx;

        // Top and bottom two tile rows are laid out row-major; the middle is column-major, mirrored in x.
        if (ty < 6'd2) begin
            offset = 10'h3C2 + {4'b0, ty[0], 5'b0} + {5'b0, inv_tx};
        end else if (ty < 6'd34) begin
            offset = 10'h040 + {inv_tx, 5'b0} + {4'b0, ty - 6'd2};
        end else begin
            offset = 10'h002 + {4'b0, ty[0], 5'b0} + {5'b0, inv_tx};
        end

        tile_ram_addr_d = active ? TILE_RAM_BASE + {6'b0, offset} : TILE_RAM_BASE;
        pal_ram_addr_d  = active ? PAL_RAM_BASE + {6'b0, offset} : PAL_RAM_BASE;
        py1_d           = row_rel[2:0];
        px1_d           = col_rel[2:0];
        act1_d          = active;

        tile_rom_addr_d = {tile_RAM_data, py1_q, px1_q[2]};
        pal_code_d      = palette_RAM_data[5:0];
        px2_d           = px1_q[1:0];
        act2_d          = act1_q;

        // Leftmost pixel of each ROM byte sits in the two MSBs.
        case (px2_q)
            2'd0:    pixel = tile_ROM_data[7:6];
            2'd1:    pixel = tile_ROM_data[5:4];
            2'd2:    pixel = tile_ROM_data[3:2];
            default: pixel = tile_ROM_data[1:0];
        endcase
        pal_rom_addr_d  = {pal_code_q, pixel};
        act3_d          = act2_q;

        red_d   = act3_q ? {palette_ROM_data[2:0], palette_ROM_data[2]} : 4'h0;
        green_d = act3_q ? {palette_ROM_data[5:3], palette_ROM_data[5]} : 4'h0;
        blue_d  = act3_q ? {palette_ROM_data[7:6], palette_ROM_data[7:6]} : 4'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_ram_addr_q <= '0;
            pal_ram_addr_q  <= '0;
            py1_q           <= '0;
            px1_q           <= '0;
            act1_q          <= 1'b0;
            tile_rom_addr_q <= '0;
            pal_code_q      <= '0;
            px2_q           <= '0;
            act2_q          <= 1'b0;
            pal_rom_addr_q  <= '0;
            act3_q          <= 1'b0;
            red_q           <= '0;
            green_q         <= '0;
            blue_q          <= '0;
        end else begin
            tile_ram_addr_q <= tile_ram_addr_d;
            pal_ram_addr_q  <= pal_ram_addr_d;
            py1_q           <= py1_d;
            px1_q           <= px1_d;
            act1_q          <= act1_d;
            tile_rom_addr_q <= tile_rom_addr_d;
            pal_code_q      <= pal_code_d;
            px2_q           <= px2_d;
            act2_q          <= act2_d;
            pal_rom_addr_q  <= pal_rom_addr_d;
            act3_q          <= act3_d;
            red_q           <= red_d;
            green_q         <= green_d;
            blue_q          <= blue_d;
        end
    end

    assign tile_RAM_addr    = tile_ram_addr_q;
    assign palette_RAM_addr = pal_ram_addr_q;
    assign tile_ROM_addr    = tile_rom_addr_q;
    assign palette_ROM_addr = pal_rom_addr_q;
    assign red              = red_q;
    assign green            = green_q;
    assign blue             = blue_q;

endmodule

// File: tb/tb_tile_block.sv
// Directed-vector bench for tile_block: fixed memory data for hand-computed cases,
// then a streaming sweep against a reference model with address-driven memory contents.
module tb_tile_block;

    logic        clk;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [15:0] tile_RAM_addr;
    logic [7:0]  tile_RAM_data;
    logic [15:0] palette_RAM_addr;
    logic [7:0]  palette_RAM_data;
    logic [11:0] tile_ROM_addr;
    logic [7:0]  tile_ROM_data;
    logic [7:0]  palette_ROM_addr;
    logic [7:0]  palette_ROM_data;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    logic        useModel;
    logic [7:0]  ovrTileRam;
    logic [7:0]  ovrPalRam;
    logic [7:0]  ovrTileRom;
    logic [7:0]  ovrPalRom;

    int errors;
    int checks;

    typedef struct packed {
        logic [15:0] taddr;
        logic [11:0] rgb;
    } exp_t;

    exp_t expQ[$];

    tile_block dut (
        .clk              (clk),
        .rst              (rst),
        .row              (row),
        .col              (col),
        .tile_RAM_addr    (tile_RAM_addr),
        .tile_RAM_data    (tile_RAM_data),
        .palette_RAM_addr (palette_RAM_addr),
        .palette_RAM_data (palette_RAM_data),
        .tile_ROM_addr    (tile_ROM_addr),
        .tile_ROM_data    (tile_ROM_data),
        .palette_ROM_addr (palette_ROM_addr),
        .palette_ROM_data (palette_ROM_data),
        .red              (red),
        .green            (green),
        .blue             (blue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synthetic memory contents as pure functions of address
    function automatic int tmem(input int a);
        return ((a * 37) >> 2) & 255;
    endfunction

    function automatic int pmem(input int a);
        return (a * 13 + (a >> 3)) & 255;
    endfunction

    function automatic int rmem(input int a);
        return ((a * 29) ^ (a >> 4)) & 255;
    endfunction

    function automatic int cmem(input int a);
        return (a * 53 + 7) & 255;
    endfunction

    // Memories answer from the registered address, giving one clock of read latency
    assign tile_RAM_data    = useModel ? 8'(tmem(int'(tile_RAM_addr)))    : ovrTileRam;
    assign palette_RAM_data = useModel ? 8'(pmem(int'(palette_RAM_addr))) : ovrPalRam;
    assign tile_ROM_data    = useModel ? 8'(rmem(int'(tile_ROM_addr)))    : ovrTileRom;
    assign palette_ROM_data = useModel ? 8'(cmem(int'(palette_ROM_addr))) : ovrPalRom;

    // Reference model of one pixel: expected VRAM tile address and final RGB
    function automatic exp_t modelPixel(input int r, input int c);
        exp_t e;
        int ty, py, tx, px, off, tcode, pcode, raddr, rd, pix, cb, rr, gg, bb;
        if (!(r >= 96 && r < 384 && c >= 208 && c < 432)) begin
            e.taddr = 16'h4000;
            e.rgb   = 12'h000;
            return e;
        end
        ty = (r - 96) / 8;
        py = (r - 96) % 8;
        tx = (c - 208) / 8;
        px = (c - 208) % 8;
        if (ty < 2)       off = 'h3C2 + ty * 32 + (27 - tx);
        else if (ty < 34) off = 'h040 + (27 - tx) * 32 + (ty - 2);
        else              off = 'h002 + (ty - 34) * 32 + (27 - tx);
        tcode = tmem('h4000 + off);
        pcode = pmem('h4400 + off) & 63;
        raddr = tcode * 16 + py * 2 + px / 4;
        rd    = rmem(raddr);
        pix   = (rd >> (6 - 2 * (px % 4))) & 3;
        cb    = cmem(pcode * 4 + pix);
        rr    = cb & 7;
        gg    = (cb >> 3) & 7;
        bb    = (cb >> 6) & 3;
        e.taddr = 16'('h4000 + off);
        e.rgb   = 12'(((rr * 2 + (rr >> 2)) << 8) | ((gg * 2 + (gg >> 2)) << 4) | (bb * 4 + bb));
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input int c);
        row = 9'(r);
        col = 10'(c);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setOverrides(input logic [7:0] tr, input logic [7:0] pr,
                                input logic [7:0] tm, input logic [7:0] pm);
        ovrTileRam = tr;
        ovrPalRam  = pr;
        ovrTileRom = tm;
        ovrPalRom  = pm;
    endtask

    function automatic logic [11:0] rgbNow();
        return {red, green, blue};
    endfunction

    // One streamed pixel per clock; tile address lags by one, RGB by four
    task automatic streamPixel(input int r, input int c);
        exp_t e;
        applyStimulus(r, c);
        e = modelPixel(r, c);
        expQ.push_back(e);
        waitEdges(1);
        checkOutput($sformatf("sweep_taddr r%0d c%0d", r, c),
                    32'(tile_RAM_addr), 32'(expQ[expQ.size() - 1].taddr));
        if (expQ.size() == 4) begin
            checkOutput("sweep_rgb", 32'(rgbNow()), 32'(expQ[0].rgb));
            void'(expQ.pop_front());
        end
    endtask

    int bRows[10] = '{0, 95, 96, 97, 200, 383, 384, 479, 500, 511};
    int bCols[10] = '{0, 207, 208, 209, 320, 431, 432, 639, 700, 1023};

    initial begin
        errors   = 0;
        checks   = 0;
        useModel = 1'b0;
        setOverrides(8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        applyStimulus(150, 300);

        waitEdges(2);
        checkOutput("reset_taddr",  32'(tile_RAM_addr),    32'h0);
        checkOutput("reset_paddr",  32'(palette_RAM_addr), 32'h0);
        checkOutput("reset_romaddr", 32'(tile_ROM_addr),   32'h0);
        checkOutput("reset_palrom", 32'(palette_ROM_addr), 32'h0);
        checkOutput("reset_rgb",    32'(rgbNow()),         32'h0);
        rst = 1'b1;

        applyStimulus(96, 208);
        waitEdges(1);
        checkOutput("addr_ty0_tile", 32'(tile_RAM_addr),    32'h43DD);
        checkOutput("addr_ty0_pal",  32'(palette_RAM_addr), 32'h47DD);
        applyStimulus(112, 208);
        waitEdges(1);
        checkOutput("addr_ty2_tile", 32'(tile_RAM_addr),    32'h43A0);
        checkOutput("addr_ty2_pal",  32'(palette_RAM_addr), 32'h47A0);
        applyStimulus(383, 431);
        waitEdges(1);
        checkOutput("addr_ty35_tile", 32'(tile_RAM_addr),    32'h4022);
        checkOutput("addr_ty35_pal",  32'(palette_RAM_addr), 32'h4422);
        applyStimulus(200, 300);
        waitEdges(1);
        checkOutput("addr_mid_tile", 32'(tile_RAM_addr),    32'h424B);
        checkOutput("addr_mid_pal",  32'(palette_RAM_addr), 32'h464B);

        // Single active pixel (py=3, px=5) walking through all four stages
        setOverrides(8'h41, 8'h05, 8'h20, 8'h07);
        applyStimulus(0, 0);
        waitEdges(5);
        checkOutput("pipe_pre_rgb", 32'(rgbNow()), 32'h0);
        applyStimulus(99, 213);
        waitEdges(1);
        checkOutput("pipe_e1_taddr", 32'(tile_RAM_addr), 32'h43DD);
        applyStimulus(0, 0);
        waitEdges(1);
        checkOutput("pipe_e2_romaddr", 32'(tile_ROM_addr), 32'h417);
        waitEdges(1);
        checkOutput("pipe_e3_palrom", 32'(palette_ROM_addr), 32'h16);
        checkOutput("pipe_e3_rgb_early", 32'(rgbNow()), 32'h0);
        waitEdges(1);
        checkOutput("pipe_e4_rgb", 32'(rgbNow()), 32'hF00);
        waitEdges(1);
        checkOutput("pipe_e5_rgb_after", 32'(rgbNow()), 32'h0);

        // Inactive pixel with all-ones memory data must still give black
        setOverrides(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(150, 300);
        waitEdges(5);
        checkOutput("ff_active_rgb", 32'(rgbNow()), 32'hFFF);
        applyStimulus(0, 0);
        waitEdges(1);
        checkOutput("ff_idle_taddr", 32'(tile_RAM_addr),    32'h4000);
        checkOutput("ff_idle_paddr", 32'(palette_RAM_addr), 32'h4400);
        waitEdges(2);
        checkOutput("ff_hold_rgb", 32'(rgbNow()), 32'hFFF);
        waitEdges(1);
        checkOutput("ff_idle_rgb", 32'(rgbNow()), 32'h0);

        // Out-of-range scan position
        applyStimulus(150, 300);
        waitEdges(5);
        applyStimulus(500, 700);
        waitEdges(1);
        checkOutput("oor_taddr", 32'(tile_RAM_addr), 32'h4000);
        waitEdges(3);
        checkOutput("oor_rgb", 32'(rgbNow()), 32'h0);

        // Pixel value 0 takes its colour from palette entry 0; upper palette bits ignored
        setOverrides(8'h10, 8'hC5, 8'h00, 8'hC0);
        applyStimulus(96, 208);
        waitEdges(3);
        checkOutput("pix0_palrom", 32'(palette_ROM_addr), 32'h14);
        waitEdges(1);
        checkOutput("pix0_rgb", 32'(rgbNow()), 32'h00F);

        // Pixel selection across px[1:0] and the px[2] half-tile bit
        setOverrides(8'h10, 8'hEA, 8'h1B, 8'h00);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(96, 208 + p);
            waitEdges(3);
            checkOutput($sformatf("pixsel_p%0d", p), 32'(palette_ROM_addr), 32'(8'hA8 + p));
        end
        applyStimulus(97, 212);
        waitEdges(2);
        checkOutput("romaddr_py1_px4", 32'(tile_ROM_addr), 32'h103);

        // Asynchronous reset mid-stream, then four-clock refill
        setOverrides(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(150, 300);
        waitEdges(5);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_taddr",   32'(tile_RAM_addr),    32'h0);
        checkOutput("arst_paddr",   32'(palette_RAM_addr), 32'h0);
        checkOutput("arst_romaddr", 32'(tile_ROM_addr),    32'h0);
        checkOutput("arst_palrom",  32'(palette_ROM_addr), 32'h0);
        checkOutput("arst_rgb",     32'(rgbNow()),         32'h0);
        waitEdges(1);
        rst = 1'b1;
        waitEdges(3);
        checkOutput("refill_rgb_3", 32'(rgbNow()), 32'h0);
        waitEdges(1);
        checkOutput("refill_rgb_4", 32'(rgbNow()), 32'hFFF);

        // Streaming sweep: window boundaries, then a coarse grid over the whole frame
        useModel = 1'b1;
        expQ.delete();
        foreach (bRows[i]) begin
            foreach (bCols[j]) begin
                streamPixel(bRows[i], bCols[j]);
            end
        end
        for (int r = 0; r < 480; r += 23) begin
            for (int c = 0; c < 640; c += 19) begin
                streamPixel(r, c);
            end
        end
        for (int k = 0; k < 3; k++) begin
            streamPixel(0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_block.md
Name: tile_block

Overview:
Pac-Man-style background tile renderer for a 640x480 VGA scan. It maps the current pixel (row, col) onto a centred 224x288 playfield of 28x36 tiles, each 8x8 pixels. It fetches the tile code and palette code from video RAM, decodes 2bpp pixel data from the tile ROM, and looks up the final colour in the palette ROM. It sits between the VGA timing generator and the pixel mixer/DAC.

Parameters:
H_OFF, 208, first active column ((640-224)/2)
V_OFF, 96, first active row ((480-288)/2)
TILE_RAM_BASE, 16'h4000, tile-code RAM base address
PAL_RAM_BASE, 16'h4400, palette-code RAM base address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
row  in  9  current scan row, 0..479
col  in  10  current scan column, 0..639
tile_RAM_addr  out  16  tile-code RAM byte address
tile_RAM_data  in  8  tile code, valid 1 clk after address
palette_RAM_addr  out  16  palette-code RAM byte address
palette_RAM_data  in  8  palette byte; bits [5:0] are the palette code
tile_ROM_addr  out  12  character ROM address
tile_ROM_data  in  8  4 pixels x 2bpp
palette_ROM_addr  out  8  {palette_code[5:0], pixel[1:0]}
palette_ROM_data  in  8  colour byte: [2:0] R, [5:3] G, [7:6] B
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue

Behaviour:
- Reset (rst=0, asynchronous): every registered output and pipeline register goes to 0, including all addresses and RGB.
- Active region: V_OFF <= row < V_OFF+288 and H_OFF <= col < H_OFF+224.
  - ty = (row-V_OFF)>>3 (0..35), py = (row-V_OFF)[2:0].
  - tx = (col-H_OFF)>>3 (0..27), px = (col-H_OFF)[2:0].
- VRAM offset, 10 bits:
  - ty 0..1: 0x3C2 + ty*0x20 + (27-tx)
  - ty 2..33: 0x040 + (27-tx)*0x20 + (ty-2)
  - ty 34..35: 0x002 + (ty-34)*0x20 + (27-tx)
- Pipeline; all stages register on posedge clk; all memories are synchronous with 1-clk read latency.
  - E1: tile_RAM_addr = TILE_RAM_BASE + offset and palette_RAM_addr = PAL_RAM_BASE + offset, registered. Outside the active region they are TILE_RAM_BASE and PAL_RAM_BASE.
  - E2: tile_ROM_addr = {tile_RAM_data, py, px[2]}, registered (16 bytes per tile, 2 bytes per line). palette_RAM_data[5:0] is captured at the same edge.
  - E3: pixel = tile_ROM_data[7-2p -: 2] with p = px[1:0], so the leftmost pixel is in the MSBs. palette_ROM_addr = {palette_code, pixel}, registered.
  - E4: colour byte expanded and registered: red = {R, R[2]}, green = {G, G[2]}, blue = {B, B}.
- Latency: RGB for the pixel sampled at edge k is valid after edge k+4. Addresses lead by 1, 2 and 3 clocks respectively.
- px, py and the active flag are delayed in step with their data. If the pixel was outside the active region, RGB = 0 at E4 regardless of memory data.
- Pixel value 0 is not forced to black; palette entry 0 decides its colour.
- New row/col may change every clock; the pipeline is fully streaming with no stalls and no handshake.
- Out-of-range inputs (row >= 480 or col >= 640) are treated as outside the active region.
- Reset mid-stream flushes the pipeline. The first valid RGB appears 4 clocks after release.

Test Plan:
- rst=0 pulse mid-run -> all addresses and RGB become 0 immediately (asynchronously).
- row=96, col=208 (ty=0, tx=0) -> after 1 clk: tile_RAM_addr=0x43DD, palette_RAM_addr=0x47DD.
- row=112, col=208 (ty=2, tx=0) -> 0x43A0 / 0x47A0. row=383, col=431 (ty=35, tx=27) -> 0x4022 / 0x4422.
- Active pixel with py=3, px=5, tile_RAM_data=0x41 -> tile_ROM_addr=0x417. Then palette_RAM_data=0x05 with tile_ROM_data=0x20 -> pixel=2, palette_ROM_addr=0x16. Then palette_ROM_data=0x07 -> red=0xF, green=0, blue=0, exactly 4 clks after the pixel was sampled.
- row=0, col=0 with all memory data 0xFF -> addresses 0x4000/0x4400 and RGB=0 after 4 clks.
- Full 640x480 sweep, each pixel held 3 clks -> no X on any output; RGB=0 everywhere outside the 224x288 window.
